// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - streaming bit-reversal reorder buffer with ping-pong banks
// Bit-reversed FFT output in, natural-order frames out, one complex sample per cycle.
module fft_bitrev_reorder #(
   parameter int DATA_W = 16,
   parameter int LOG2N  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sop,
   input  logic              bypass,
   input  logic [DATA_W-1:0] in_r,
   input  logic [DATA_W-1:0] in_i,
   output logic              out_valid,
   output logic              out_sop,
   output logic              out_eop,
   output logic [DATA_W-1:0] out_r,
   output logic [DATA_W-1:0] out_i,
   output logic              frame_err
);

   localparam int N = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST = '1;

   typedef enum logic {R_IDLE, R_STREAM} rstate_t;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
      logic [LOG2N-1:0] r;
      for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
      return r;
   endfunction

   logic [2*DATA_W-1:0] mem [2][N];
   logic [1:0]          full, full_n;
   logic                wr_bank, wr_bank_n, rd_bank, rd_bank_n;
   logic                wr_active, wr_active_n, bypass_l, bypass_n;
   logic [LOG2N-1:0]    wr_cnt, wr_cnt_n, cnt_eff, wr_addr, rd_cnt, rd_cnt_n;
   logic                wr_en, bp_eff, err, set_full, sop_ok;
   logic                rd_clear, rd_load;
   rstate_t             state, state_n;

   always_comb begin
      state_n   = state;
      rd_cnt_n  = rd_cnt;
      rd_bank_n = rd_bank;
      rd_clear  = 1'b0;
      rd_load   = 1'b0;
      case (state)
         R_IDLE: begin
            if (full[rd_bank]) begin
               state_n  = R_STREAM;
               rd_cnt_n = '0;
            end
         end
         R_STREAM: begin
            rd_load  = 1'b1;
            rd_cnt_n = rd_cnt + 1'b1;
            if (rd_cnt == LAST) begin
               // Hand over to the other bank with no bubble if it is already full.
               rd_clear  = 1'b1;
               rd_bank_n = ~rd_bank;
               rd_cnt_n  = '0;
               if (!full[~rd_bank]) state_n = R_IDLE;
            end
         end
         default: state_n = R_IDLE;
      endcase
   end

   // A bank being released by the reader this edge may be restarted this same edge.
   assign sop_ok = !full[wr_bank] || (rd_clear && (rd_bank == wr_bank));

   always_comb begin
      wr_en       = 1'b0;
      err         = 1'b0;
      set_full    = 1'b0;
      wr_active_n = wr_active;
      wr_cnt_n    = wr_cnt;
      wr_bank_n   = wr_bank;
      bypass_n    = bypass_l;
      cnt_eff     = wr_cnt;
      bp_eff      = bypass_l;
      if (in_valid) begin
         if (in_sop) begin
            err = wr_active;
            if (sop_ok) begin
               wr_en    = 1'b1;
               cnt_eff  = '0;
               bp_eff   = bypass;
               bypass_n = bypass;
            end else begin
               err         = 1'b1;
               wr_active_n = 1'b0;
            end
         end else if (wr_active) begin
            wr_en = 1'b1;
         end else begin
            err = 1'b1;
         end
      end
      if (wr_en) begin
         if (cnt_eff == LAST) begin
            set_full    = 1'b1;
            wr_bank_n   = ~wr_bank;
            wr_active_n = 1'b0;
            wr_cnt_n    = '0;
         end else begin
            wr_active_n = 1'b1;
            wr_cnt_n    = cnt_eff + 1'b1;
         end
      end
      wr_addr = bp_eff ? cnt_eff : bitrev(cnt_eff);
      full_n  = full;
      if (rd_clear) full_n[rd_bank] = 1'b0;
      if (set_full) full_n[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_bank][wr_addr] <= {in_r, in_i};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= R_IDLE;
         rd_cnt    <= '0;
         rd_bank   <= 1'b0;
         wr_bank   <= 1'b0;
         wr_cnt    <= '0;
         wr_active <= 1'b0;
         bypass_l  <= 1'b0;
         full      <= '0;
         out_valid <= 1'b0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_r     <= '0;
         out_i     <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         rd_cnt    <= rd_cnt_n;
         rd_bank   <= rd_bank_n;
         wr_bank   <= wr_bank_n;
         wr_cnt    <= wr_cnt_n;
         wr_active <= wr_active_n;
         bypass_l  <= bypass_n;
         full      <= full_n;
         frame_err <= err;
         out_valid <= rd_load;
         out_sop   <= rd_load && (rd_cnt == '0);
         out_eop   <= rd_load && (rd_cnt == LAST);
         if (rd_load) {out_r, out_i} <= mem[rd_bank][rd_cnt];
      end
   end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - randomized self-checking bench for fft_bitrev_reorder
// Expected output frames are built from the sent samples with an arithmetic bit reversal.
module tb_fft_bitrev_reorder;

   localparam int DATA_W = 16;
   localparam int LOG2N  = 5;
   localparam int N      = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              in_valid = 1'b0, in_sop = 1'b0, bypass = 1'b0;
   logic [DATA_W-1:0] in_r = '0, in_i = '0;
   logic              out_valid, out_sop, out_eop, frame_err;
   logic [DATA_W-1:0] out_r, out_i;

   fft_bitrev_reorder #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop), .bypass(bypass),
      .in_r(in_r), .in_i(in_i), .out_valid(out_valid), .out_sop(out_sop),
      .out_eop(out_eop), .out_r(out_r), .out_i(out_i), .frame_err(frame_err));

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] r;
      logic [DATA_W-1:0] i;
      logic              sop;
      logic              eop;
   } exp_t;

   exp_t              q[$];
   exp_t              e_m;
   logic [DATA_W-1:0] fr[N], fi[N];
   int total = 0, bad = 0;
   int cyc = 0, last_in_edge = 0;
   int err_cycles = 0, exp_err = 0;
   int valid_cnt = 0, run = 0, max_run = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rev(input int j);
      int r = 0, x = j;
      for (int b = 0; b < LOG2N; b++) begin
         r = r * 2 + x % 2;
         x = x / 2;
      end
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (frame_err) err_cycles++;
         if (out_valid) begin
            valid_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (q.size() == 0) check("unexpected_out", 1, 0);
            else begin
               e_m = q.pop_front();
               check("data", {out_r, out_i}, {e_m.r, e_m.i});
               check("sop", out_sop, e_m.sop);
               check("eop", out_eop, e_m.eop);
            end
         end else begin
            run = 0;
            check("idle_flags", {out_sop, out_eop}, 0);
         end
      end
   end

   task automatic send_frame(input bit bp, input int len, input int gap, input bit ramp);
      int idx;
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_sop   = (k == 0);
         bypass   = bp;
         if (ramp) begin
            in_r = DATA_W'(k);
            in_i = DATA_W'(-k);
         end else begin
            in_r = DATA_W'($urandom);
            in_i = DATA_W'($urandom);
         end
         fr[k] = in_r;
         fi[k] = in_i;
         last_in_edge = cyc + 1;
         if (gap > 0 && k < len - 1)
            repeat (gap) begin
               @(negedge clk);
               in_valid = 1'b0;
               in_sop   = 1'b0;
            end
      end
      if (len == N)
         for (int j = 0; j < N; j++) begin
            idx = bp ? j : rev(j);
            q.push_back('{fr[idx], fi[idx], j == 0, j == N - 1});
         end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sop   = 1'b0;
      end
   endtask

   task automatic wait_sop();
      bit found = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sop   = 1'b0;
         if (out_valid && out_sop) begin
            found = 1;
            break;
         end
      end
      check("sop_timeout", found, 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 600; t++) begin
         if (q.size() == 0) break;
         idle(1);
      end
      check("drain", q.size(), 0);
      idle(3);
   endtask

   int e0, v0;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_flags", {out_sop, out_eop, frame_err}, 0);
      check("rst_data", {out_r, out_i}, 0);
      rst = 1'b1;
      idle(2);

      send_frame(0, N, 0, 1);
      wait_sop();
      check("lat_bitrev", cyc - last_in_edge, 2);
      drain();

      send_frame(1, N, 0, 1);
      wait_sop();
      check("lat_bypass", cyc - last_in_edge, 2);
      drain();

      max_run = 0;
      e0 = err_cycles;
      send_frame(0, N, 0, 0);
      send_frame(1, N, 0, 0);
      send_frame(0, N, 0, 0);
      drain();
      check("b2b_run", max_run, 3 * N);
      check("b2b_err", err_cycles - e0, 0);

      send_frame(0, N, 1, 0);
      wait_sop();
      check("lat_gapped", cyc - last_in_edge, 2);
      drain();

      exp_err = err_cycles;
      send_frame(0, 10, 0, 0);
      send_frame(0, N, 0, 0);
      exp_err++;
      @(negedge clk);
      in_valid = 1'b1;
      in_sop   = 1'b0;
      exp_err++;
      drain();
      check("err_pulses", err_cycles, exp_err);

      e0 = err_cycles;
      for (int f = 0; f < 5; f++)
         send_frame(1'($urandom_range(0, 1)), N, $urandom_range(0, 2), 0);
      drain();
      check("rand_err", err_cycles - e0, 0);

      send_frame(0, N, 0, 0);
      wait_sop();
      repeat (12) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_data", {out_r, out_i}, 0);
      q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      v0 = valid_cnt;
      idle(40);
      check("post_rst_quiet", valid_cnt - v0, 0);
      send_frame(1, N, 0, 0);
      wait_sop();
      check("lat_after_rst", cyc - last_in_edge, 2);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
